// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit data paths.
// Holds the Baud_Set code constants, the bit-period lookup and a
// constant-foldable clog2 used to size counters from parameters.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Bits needed to hold values 0..v-1 (0 for v<=1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clock cycles per bit, integer-truncated. Unused codes fall back to 115200.
  function automatic int baud_period(input logic [2:0] code, input int clk_freq);
    case (code)
      BAUD_9600:  return clk_freq / 9600;
      BAUD_19200: return clk_freq / 19200;
      BAUD_38400: return clk_freq / 38400;
      BAUD_57600: return clk_freq / 57600;
      default:    return clk_freq / 115200;
    endcase
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Silence timer: counts cycles while run_i is high and clears on clr_i or
// whenever run_i is low. expired_o is a combinational strobe that is high
// once the count has reached limit_i-1, so the owner can act on the edge
// that would otherwise take the count to limit_i.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   run_i      count enable (owner is in an active phase)
//   clr_i      restart the count from zero
//   limit_i    expiry length in cycles
//   expired_o  count has reached limit_i-1 while running
module uart_idle_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !run_i) cnt_d = '0;
    else                 cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Compare cnt+1 >= limit one bit wider: no underflow for a zero limit, and
  // a limit lowered below the current count expires immediately.
  assign expired_o = run_i &&
                     (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, limit_i});

endmodule

// File: rtl/uart_word_assembler.sv
// Collects single received bytes into a DATA_WIDTH-bit word in the chosen
// byte order, pulses Rx_Done for one cycle per completed word and drops a
// partial word after TIMEOUT_BITS bit periods of silence (timeout_flag).
// Ports:
//   Clk           system clock
//   Rst_n         synchronous active-low reset
//   byte_in       received byte, valid when byte_valid is high
//   byte_valid    one-cycle byte strobe
//   Baud_Set      baud code selecting the silence limit
//   data          last completed word, held until the next completion
//   Rx_Done       one-cycle pulse when data updates
//   timeout_flag  one-cycle pulse when a partial word is discarded
//   byte_cnt      bytes held in the current partial word
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MSB_FIRST    = 0,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                                    Clk,
  input  logic                                    Rst_n,
  input  logic [7:0]                              byte_in,
  input  logic                                    byte_valid,
  input  logic [2:0]                              Baud_Set,
  output logic [DATA_WIDTH-1:0]                   data,
  output logic                                    Rx_Done,
  output logic                                    timeout_flag,
  output logic [clog2(DATA_WIDTH/8+1)-1:0]        byte_cnt
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CNT_W  = clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  // Timer is sized for the slowest rate; faster rates use a shorter limit.
  localparam int LIM_9600   = TIMEOUT_BITS * baud_period(BAUD_9600,   CLK_FREQ);
  localparam int LIM_19200  = TIMEOUT_BITS * baud_period(BAUD_19200,  CLK_FREQ);
  localparam int LIM_38400  = TIMEOUT_BITS * baud_period(BAUD_38400,  CLK_FREQ);
  localparam int LIM_57600  = TIMEOUT_BITS * baud_period(BAUD_57600,  CLK_FREQ);
  localparam int LIM_115200 = TIMEOUT_BITS * baud_period(BAUD_115200, CLK_FREQ);
  localparam int TMR_W      = clog2(LIM_9600 + 1);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  logic                  state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] sh_shift;
  logic [TMR_W-1:0]      limit;
  logic                  expired;

  always_comb begin
    case (Baud_Set)
      BAUD_9600:  limit = TMR_W'(LIM_9600);
      BAUD_19200: limit = TMR_W'(LIM_19200);
      BAUD_38400: limit = TMR_W'(LIM_38400);
      BAUD_57600: limit = TMR_W'(LIM_57600);
      default:    limit = TMR_W'(LIM_115200);
    endcase
  end

  uart_idle_timer #(
    .CNT_W (TMR_W)
  ) u_idle_timer (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .run_i     (state_q == ST_COLLECT),
    .clr_i     (byte_valid),
    .limit_i   (limit),
    .expired_o (expired)
  );

  // Shift register contents after accepting byte_in this cycle.
  generate
    if (NBYTES == 1) begin : g_single
      assign sh_shift = byte_in;
    end else if (MSB_FIRST != 0) begin : g_msb_first
      assign sh_shift = {sh_q[DATA_WIDTH-9:0], byte_in};
    end else begin : g_lsb_first
      assign sh_shift = {byte_in, sh_q[DATA_WIDTH-1:8]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (byte_valid) begin
      if (cnt_q == LAST) begin
        data_d  = sh_shift;
        sh_d    = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        sh_d    = sh_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_COLLECT;
      end
    end else if (expired) begin
      sh_d    = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
      tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign data         = data_q;
  assign Rx_Done      = done_q;
  assign timeout_flag = tmo_q;
  assign byte_cnt     = cnt_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: two instances (LSB-first and MSB-first)
// share one byte stream; expected Rx_Done words and timeout pulses, with
// their cycle stamps, are queued per instance and checked by a monitor.
module tb_uart_word_assembler;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [2:0]  Baud_Set;
  logic [31:0] data0, data1;
  logic        done0, done1, tmo0, tmo1;
  logic [2:0]  cnt0, cnt1;

  always #5 Clk = ~Clk;

  uart_word_assembler #(.DATA_WIDTH(32), .MSB_FIRST(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .Baud_Set(Baud_Set), .data(data0), .Rx_Done(done0),
    .timeout_flag(tmo0), .byte_cnt(cnt0)
  );

  uart_word_assembler #(.DATA_WIDTH(32), .MSB_FIRST(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .Baud_Set(Baud_Set), .data(data1), .Rx_Done(done1),
    .timeout_flag(tmo1), .byte_cnt(cnt1)
  );

  typedef struct {
    bit          is_tmo;
    logic [31:0] val;
    int          cyc;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_strobe = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input logic done, input logic tmo, input logic [31:0] d);
    evt_t e;
    bit   have;
    if (done || tmo) begin
      check($sformatf("dut%0d_done_tmo_exclusive", id), 32'(done & tmo), 32'd0);
      have = 1'b0;
      if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        vectors++;
        miscompares++;
        $display("FAIL dut%0d_unexpected_event: got done=%0b tmo=%0b required none (cycle %0d)",
                 id, done, tmo, cyc);
      end else begin
        check($sformatf("dut%0d_event_kind", id), 32'(tmo), 32'(e.is_tmo));
        check($sformatf("dut%0d_event_cycle", id), 32'(cyc), 32'(e.cyc));
        if (!e.is_tmo) check($sformatf("dut%0d_word", id), d, e.val);
      end
    end
  endtask

  always @(negedge Clk) begin
    mon(0, done0, tmo0, data0);
    mon(1, done1, tmo1, data1);
  end

  // Called at a negedge; strobes the byte on the next posedge and returns at
  // the following negedge. Completion words are queued before the strobe.
  task automatic send(input logic [7:0] b, input bit last,
                      input logic [31:0] w0, input logic [31:0] w1);
    evt_t e;
    byte_in     = b;
    byte_valid  = 1'b1;
    last_strobe = cyc;
    if (last) begin
      e.is_tmo = 1'b0; e.cyc = last_strobe + 1;
      e.val = w0; q0.push_back(e);
      e.val = w1; q1.push_back(e);
    end
    @(negedge Clk);
    byte_valid = 1'b0;
  endtask

  task automatic push_tmo(input int offset);
    evt_t e;
    e.is_tmo = 1'b1;
    e.val    = '0;
    e.cyc    = last_strobe + offset;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    Baud_Set   = 3'd4;
    idle(3);
    check("rst_data0", data0, 32'h0);
    check("rst_data1", data1, 32'h0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_pulses", {30'd0, done0 | done1, tmo0 | tmo1}, 32'd0);
    Rst_n = 1'b1;
    idle(2);

    // Byte order, 10 bit periods at 115200 between bytes.
    send(8'h11, 0, 0, 0); idle(4339);
    send(8'h22, 0, 0, 0); idle(4339);
    send(8'h33, 0, 0, 0); idle(4339);
    send(8'h44, 1, 32'h44332211, 32'h11223344);
    check("t1_cnt_back_to_0", 32'(cnt0), 32'd0);
    idle(10);

    // Second word; previous word must hold until the 4th strobe.
    send(8'hAA, 0, 0, 0); idle(100);
    send(8'hBB, 0, 0, 0); idle(100);
    send(8'hCC, 0, 0, 0); idle(100);
    check("t2_cnt_partial", 32'(cnt1), 32'd3);
    check("t2_hold_data0", data0, 32'h44332211);
    check("t2_hold_data1", data1, 32'h11223344);
    send(8'hDD, 1, 32'hDDCCBBAA, 32'hAABBCCDD);
    idle(10);

    // Timeout: flag 8680 cycles after the 2nd strobe.
    send(8'h55, 0, 0, 0); idle(50);
    send(8'h66, 0, 0, 0);
    push_tmo(8681);
    idle(9000);
    check("t3_cnt_after_tmo", 32'(cnt0), 32'd0);
    check("t3_data0_unchanged", data0, 32'hDDCCBBAA);
    send(8'h01, 0, 0, 0); idle(20);
    send(8'h02, 0, 0, 0); idle(20);
    send(8'h03, 0, 0, 0); idle(20);
    send(8'h04, 1, 32'h04030201, 32'h01020304);
    idle(10);

    // Race: second byte lands on the cycle the timer reaches limit-1.
    send(8'h10, 0, 0, 0); idle(8679);
    send(8'h20, 0, 0, 0);
    check("t4_race_cnt", 32'(cnt0), 32'd2);
    idle(20);
    send(8'h30, 0, 0, 0); idle(20);
    send(8'h40, 1, 32'h40302010, 32'h10203040);
    idle(10);

    // Mid-word reset discards the partial word silently.
    send(8'h91, 0, 0, 0); idle(5);
    send(8'h92, 0, 0, 0); idle(5);
    send(8'h93, 0, 0, 0); idle(5);
    Rst_n = 1'b0;
    idle(1);
    Rst_n = 1'b1;
    check("t5_rst_data0", data0, 32'h0);
    check("t5_rst_data1", data1, 32'h0);
    check("t5_rst_cnt0", 32'(cnt0), 32'd0);
    idle(5);
    send(8'hDE, 0, 0, 0); idle(5);
    send(8'hAD, 0, 0, 0); idle(5);
    send(8'hBE, 0, 0, 0); idle(5);
    send(8'hEF, 1, 32'hEFBEADDE, 32'hDEADBEEF);
    idle(10);

    // Baud switch: 9000 idle cycles at 9600, then 115200 -> expire next cycle.
    Baud_Set = 3'd0;
    send(8'h99, 0, 0, 0);
    idle(9000);
    push_tmo(9002);
    Baud_Set = 3'd4;
    idle(3);
    check("t6_cnt_after_switch", 32'(cnt0), 32'd0);

    // Unused code 7 behaves as 115200.
    Baud_Set = 3'd7;
    send(8'h5A, 0, 0, 0);
    push_tmo(8681);
    idle(9000);
    check("t7_cnt_after_tmo", 32'(cnt1), 32'd0);
    check("t7_data1_unchanged", data1, 32'hDEADBEEF);

    idle(20);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
Upstream stage of the multi-byte UART receive path. Collects bytes from the single-byte UART receiver into one DATA_WIDTH-bit word, honouring MSB_FIRST byte order. Emits a one-cycle done pulse per complete word. Discards partial words after an inter-byte silence timeout scaled to the selected baud rate.

Parameters:
DATA_WIDTH, 32, output word width; multiple of 8, minimum 8; NBYTES = DATA_WIDTH/8
MSB_FIRST, 0, 0 = first received byte lands in data[7:0]; 1 = first byte lands in data[DATA_WIDTH-1:DATA_WIDTH-8]
CLK_FREQ, 50_000_000, Clk frequency in Hz, used for bit-period lookup
TIMEOUT_BITS, 20, silence length in bit periods that aborts a partial word

Ports:
Clk  input  1  system clock
Rst_n  input  1  reset; Rst_n is synchronous and active-low
byte_in  input  8  received byte from the byte receiver
byte_valid  input  1  one-cycle strobe; byte_in is valid in this cycle
Baud_Set  input  3  0:9600 1:19200 2:38400 3:57600 4:115200; codes 5-7 select 115200
data  output  DATA_WIDTH  last completed word, held until the next completion
Rx_Done  output  1  one-cycle pulse when data updates
timeout_flag  output  1  one-cycle pulse when a partial word is discarded
byte_cnt  output  clog2(NBYTES+1)  bytes held in the current partial word

Behaviour:
- Reset (Rst_n=0 at a Clk edge): data=0, Rx_Done=0, timeout_flag=0, byte_cnt=0, shift register=0, idle timer=0, state=IDLE.
- States:
  - IDLE: byte_cnt=0.
  - COLLECT: 0<byte_cnt<NBYTES.
  - Completion is not a separate state. It is the transition back to IDLE.
- Shift rules on a byte_valid cycle:
  - MSB_FIRST=1: sh <= {sh[DATA_WIDTH-9:0], byte_in}.
  - MSB_FIRST=0: sh <= {byte_in, sh[DATA_WIDTH-1:8]}.
- Byte accounting: byte_cnt increments on each byte_valid.
- Completion: when byte_valid arrives with byte_cnt==NBYTES-1:
  - data <= the assembled value, including this byte, at the same edge.
  - Rx_Done=1 for exactly the next cycle.
  - byte_cnt returns to 0 and state returns to IDLE.
- Latency: data and Rx_Done are visible 1 cycle after the final byte_valid.
- NBYTES=1: every byte_valid completes a word. The timeout never fires.
- Bit period (cycles) is combinational from Baud_Set: CLK_FREQ/baud, integer-truncated. At 50 MHz: 5208, 2604, 1302, 868, 434.
- Timeout limit: TIMEOUT_BITS * bit_period. The timer must be wide enough for the 9600 case (104160 cycles → 17 bits).
- Idle timer behaviour:
  - Clears to 0 on every byte_valid and while in IDLE.
  - Otherwise increments by 1 per cycle in COLLECT.
- Timeout: when the timer reaches limit-1 in COLLECT with no byte_valid:
  - byte_cnt <= 0 and sh <= 0; data is unchanged.
  - timeout_flag=1 for the next cycle.
  - state returns to IDLE.
- Simultaneous byte_valid and timer expiry: the byte wins. It is accepted, the timer clears, and timeout_flag is not raised.
- Rx_Done and timeout_flag are never asserted in the same cycle.
- Baud_Set change mid-word: the new limit applies immediately. If the timer already exceeds the new limit, the timeout fires on the next cycle.
- Reset mid-word: partial word lost, outputs return to reset values. No Rx_Done or timeout_flag is generated for the lost word.
- byte_valid held high for several cycles is counted once per cycle. Upstream guarantees single-cycle strobes.

Decomposition:
- Shared package uart_pkg holds:
  - Baud code constants BAUD_9600..BAUD_115200.
  - Function baud_period(code, clk_freq).
  - Function clog2.
  - Shared by uart_data_rx and uart_data_tx.
- One sub-module: uart_idle_timer. It contains the timer, the limit compare and the expiry strobe, and is reusable by the TX side for inter-frame gaps.
- The rest stays flat in uart_word_assembler.

Test Plan:
- Order, MSB_FIRST=0, DATA_WIDTH=32, Baud_Set=4: bytes 0x11,0x22,0x33,0x44 spaced 434*10 cycles → data=0x44332211, one Rx_Done pulse 1 cycle after the 4th strobe, byte_cnt back to 0.
- Order, MSB_FIRST=1, same bytes → data=0x11223344. Then four more bytes 0xAA,0xBB,0xCC,0xDD → data=0xAABBCCDD; data holds 0x11223344 until that 4th strobe.
- Timeout, Baud_Set=4: send 0x55,0x66, then silence → timeout_flag pulses exactly 8680 cycles after the 2nd strobe, byte_cnt=0, data unchanged. Next 4 bytes 0x01..0x04 form a clean word 0x04030201.
- Race: byte_valid on exactly the cycle the timer hits limit-1 → no timeout_flag, byte_cnt increments.
- Mid-word reset: 3 bytes, then Rst_n=0 for 1 cycle, then 4 bytes 0xDE,0xAD,0xBE,0xEF (MSB_FIRST=0) → outputs reset; the result is data=0xEFBEADDE with one Rx_Done and no stale-byte contamination.
- Baud switch: Baud_Set=0 with 1 byte sent; switch to 4 after 9000 idle cycles → timeout_flag on the next cycle.
